spatz_tcdm_port_arbiter: RTL

Shares one TCDM interconnect input port between `NumReq` requesters, for example a core's scalar LSU and its Spatz VLSU ports. It sits directly in front of `spatz_tcdm_interconnect`:

- arbitrates request channels round-robin, holding the grant while a request is stalled (lock-in);
- records the granted requester index of every accepted request;
- routes each returning response, in order, to that requester;
- limits outstanding requests so that no response is ever lost.

---
 rtl/spatz_tcdm_port_arbiter_pkg.sv | 31 +++
 rtl/spatz_tcdm_port_arbiter_fifo.sv | 54 +++++
 rtl/spatz_tcdm_port_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/spatz_tcdm_port_arbiter_pkg.sv
// Shared TCDM request/response payload types for the port arbiter.
// Also provides the index-width helper used to size requester indices.
package spatz_tcdm_port_arbiter_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  strb;
    logic [31:0] data;
  } tcdm_q_t;

  typedef struct packed {
    tcdm_q_t q;
    logic    q_valid;
  } tcdm_req_t;

  typedef struct packed {
    logic [31:0] data;
  } tcdm_p_t;

  typedef struct packed {
    logic    q_ready;
    tcdm_p_t p;
    logic    p_valid;
  } tcdm_rsp_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spatz_tcdm_port_arbiter_fifo.sv
// Index FIFO: remembers which requester owns each outstanding request.
// Ports: push_i/data_i in, pop_i/data_o out, full_o, empty_o, usage_o.
module spatz_tcdm_port_arbiter_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  usage_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             push, pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;

  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= inc(wr_q);
      if (pop)  rd_q <= inc(rd_q);
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/spatz_tcdm_port_arbiter.sv
// Shares one TCDM port between NumReq requesters: round-robin with lock-in,
// in-order response steering via an index FIFO, credit limit MaxOutstanding.
module spatz_tcdm_port_arbiter
  import spatz_tcdm_port_arbiter_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type req_t = spatz_tcdm_port_arbiter_pkg::tcdm_req_t,
  parameter type rsp_t = spatz_tcdm_port_arbiter_pkg::tcdm_rsp_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  req_t req_i [NumReq],
  output rsp_t rsp_o [NumReq],
  output req_t req_o,
  input  rsp_t rsp_i,
  output logic busy_o
);

  localparam int unsigned IdxW = idx_width(NumReq);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef logic [IdxW-1:0] idx_t;

  idx_t              rr_q, rr_d;
  idx_t              lock_idx_q, lock_idx_d;
  logic              lock_q, lock_d;
  idx_t              g, head;
  logic [NumReq-1:0] valid;
  logic              full, empty, hs, stall, pop;
  logic [CntW-1:0]   usage;

  // Backwards scan: the last hit is the first valid at or after ptr.
  function automatic idx_t rr_pick(input idx_t ptr,
                                   input logic [NumReq-1:0] v);
    rr_pick = ptr;
    for (int i = NumReq - 1; i >= 0; i--) begin
      int unsigned k;
      k = (32'(ptr) + 32'(i)) % NumReq;
      if (v[k]) rr_pick = idx_t'(k);
    end
  endfunction

  always_comb begin
    for (int i = 0; i < NumReq; i++) valid[i] = req_i[i].q_valid;
  end

  assign g = lock_q ? lock_idx_q : rr_pick(rr_q, valid);

  always_comb begin
    req_o         = req_i[g];
    req_o.q_valid = req_i[g].q_valid & ~full;
  end

  assign hs    = req_o.q_valid & rsp_i.q_ready;
  assign stall = req_o.q_valid & ~rsp_i.q_ready;
  assign pop   = rsp_i.p_valid & ~empty;

  // Data goes to everyone; only the ready/valid strobes are steered.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      rsp_o[i]         = rsp_i;
      rsp_o[i].q_ready = hs && (g == idx_t'(i));
      rsp_o[i].p_valid = pop && (head == idx_t'(i));
    end
  end

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (hs) begin
      rr_d   = (g == idx_t'(NumReq - 1)) ? '0 : g + 1'b1;
      lock_d = 1'b0;
    end else if (stall) begin
      lock_d     = 1'b1;
      lock_idx_d = g;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  spatz_tcdm_port_arbiter_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW),
    .CntW  (CntW)
  ) i_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .data_i  (g),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (usage)
  );

  assign busy_o = (usage != '0);

`ifndef SYNTHESIS
  a_rsp_when_empty: assert property (
    @(posedge clk_i) disable iff (!rst_ni) rsp_i.p_valid |-> !empty);
  a_lock_hold: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> req_i[lock_idx_q].q_valid);
`endif

endmodule
